// File: rtl/chunked_adder_pkg.sv
// Shared types and elaboration helpers for the chunk-serial add/subtract unit.
package chunked_adder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    // Width of the chunk index register: at least one bit, even for a single chunk.
    function automatic int idx_width(input int width, input int chunk);
        int n;
        n = width / chunk;
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic bit params_ok(input int width, input int chunk);
        return (chunk >= 1) && (chunk <= width) && ((width % chunk) == 0);
    endfunction

endpackage

// File: rtl/chunk_add_slice.sv
// Combinational CHUNK-bit ripple adder; also exposes the carry into its top bit
// so the caller can derive signed overflow on the most-significant chunk.
module chunk_add_slice
    import chunked_adder_pkg::*;
#(
    parameter int CHUNK = 2
) (
    input  logic [CHUNK-1:0] a_c,
    input  logic [CHUNK-1:0] b_c,
    input  logic             c_in,
    output logic [CHUNK-1:0] s,
    output logic             c_out,
    output logic             c_msb_in
);

    logic [CHUNK-1:0] w_sum;
    logic             w_carry;
    logic             w_msb_in;

    // NOTE: every variable gets a default before the loop so no path leaves one
    // unassigned (which would infer a latch); blocking '=' is correct here because
    // w_carry must ripple bit to bit within the same evaluation.
    always_comb begin
        w_sum    = '0;
        w_carry  = c_in;
        w_msb_in = c_in;
        for (int i = 0; i < CHUNK; i++) begin
            if (i == CHUNK - 1) begin
                w_msb_in = w_carry;
            end
            w_sum[i] = a_c[i] ^ b_c[i] ^ w_carry;
            w_carry  = (a_c[i] & b_c[i]) | (w_carry & (a_c[i] ^ b_c[i]));
        end
    end

    assign s        = w_sum;
    assign c_out    = w_carry;
    assign c_msb_in = w_msb_in;

endmodule

// File: rtl/chunked_adder.sv
// Multi-cycle add/subtract: WIDTH-bit operands summed CHUNK bits per clock,
// least-significant chunk first, with valid/ready handshakes on both sides.
module chunked_adder
    import chunked_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out,
    output logic             overflow
);

    localparam int N    = WIDTH / CHUNK;
    localparam int IDXW = idx_width(WIDTH, CHUNK);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

    if (!params_ok(WIDTH, CHUNK)) begin : g_param_check
        $error("chunked_adder: WIDTH must be a positive multiple of CHUNK");
    end

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic [IDXW-1:0]  r_idx;
    logic [WIDTH:0]   r_out;
    logic             r_overflow;

    logic             w_accept;
    logic [CHUNK-1:0] w_s;
    logic             w_c_out;
    logic             w_c_msb_in;

    // Operand registers shift right each BUSY cycle, so the active chunk is always the low one.
    chunk_add_slice #(
        .CHUNK (CHUNK)
    ) u_slice (
        .a_c      (r_a[CHUNK-1:0]),
        .b_c      (r_b[CHUNK-1:0]),
        .c_in     (r_carry),
        .s        (w_s),
        .c_out    (w_c_out),
        .c_msb_in (w_c_msb_in)
    );

    assign in_ready = !reset && ((r_state == IDLE) || ((r_state == DONE) && out_ready));
    assign w_accept = in_valid && in_ready;

    // NOTE: sequential state uses non-blocking '<=' so every register samples the
    // pre-edge values; the reset branch clears all state synchronously, which
    // also discards any operation in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= IDLE;
            r_a        <= '0;
            r_b        <= '0;
            r_carry    <= 1'b0;
            r_idx      <= '0;
            r_out      <= '0;
            r_overflow <= 1'b0;
        end else if (w_accept) begin
            // Accepting from DONE completes the output handshake on the same edge.
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_carry <= sub ? 1'b1 : cin;
            r_idx   <= '0;
            r_state <= BUSY;
        end else begin
            case (r_state)
                BUSY: begin
                    r_a              <= r_a >> CHUNK;
                    r_b              <= r_b >> CHUNK;
                    r_out[WIDTH-1:0] <= WIDTH'({w_s, r_out[WIDTH-1:0]} >> CHUNK);
                    r_carry          <= w_c_out;
                    if (r_idx == LAST_IDX) begin
                        r_idx      <= '0;
                        r_out[WIDTH] <= w_c_out;
                        r_overflow <= w_c_msb_in ^ w_c_out;
                        r_state    <= DONE;
                    end else begin
                        r_idx <= r_idx + IDXW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign out_valid = (r_state == DONE);
    assign out       = r_out;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_chunked_adder.sv
// Self-checking bench: directed scenarios on CHUNK=2 plus random ops on CHUNK=1,2,4,8
// against an arithmetic reference model.
module tb_chunked_adder;

    localparam int WIDTH = 8;
    localparam int NCFG  = 4;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic                       reset;
    logic [WIDTH-1:0]           a;
    logic [WIDTH-1:0]           b;
    logic                       cin;
    logic                       sub;
    logic [NCFG-1:0]            in_valid;
    logic [NCFG-1:0]            in_ready;
    logic [NCFG-1:0]            out_valid;
    logic [NCFG-1:0]            out_ready;
    logic [NCFG-1:0]            overflow;
    logic [NCFG-1:0][WIDTH:0]   out;

    int n_checks = 0;
    int n_errors = 0;

    for (genvar g = 0; g < NCFG; g++) begin : g_dut
        chunked_adder #(
            .WIDTH (WIDTH),
            .CHUNK (1 << g)
        ) dut (
            .clock     (clock),
            .reset     (reset),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .a         (a),
            .b         (b),
            .cin       (cin),
            .sub       (sub),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out       (out[g]),
            .overflow  (overflow[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Returns {overflow, carry/no-borrow, sum} from plain integer arithmetic.
    function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                                               input logic mcin, input logic msub);
        int full;
        int sres;
        logic ovf;
        if (msub) begin
            full = int'(ma) - int'(mb) + 256;
            sres = int'($signed(ma)) - int'($signed(mb));
        end else begin
            full = int'(ma) + int'(mb) + int'(mcin);
            sres = int'($signed(ma)) + int'($signed(mb)) + int'(mcin);
        end
        ovf = (sres > 127) || (sres < -128);
        return {ovf, full[WIDTH:0]};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Presents operands and returns just after the accepting edge.
    task automatic start_op(input int k, input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                            input logic tcin, input logic tsub);
        int w;
        a           = ta;
        b           = tb_v;
        cin         = tcin;
        sub         = tsub;
        in_valid[k] = 1'b1;
        w = 0;
        while (!in_ready[k] && w < 50) begin
            tick();
            w++;
        end
        check("accept ready", 32'(in_ready[k]), 32'd1);
        tick();
        in_valid[k] = 1'b0;
        a   = WIDTH'($urandom);
        b   = WIDTH'($urandom);
        cin = 1'($urandom);
        sub = 1'($urandom);
    endtask

    // Called just after the accepting edge; counts edges until out_valid.
    task automatic wait_result(input int k, input int exp_lat, input logic [WIDTH:0] exp_out,
                               input logic exp_ovf, input string tag);
        int lat;
        lat = 0;
        while (!out_valid[k] && lat < 64) begin
            tick();
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " out"}, 32'(out[k]), 32'(exp_out));
        check({tag, " overflow"}, 32'(overflow[k]), 32'(exp_ovf));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [WIDTH-1:0]  ra;
        logic [WIDTH-1:0]  rb;
        logic              rc;
        logic              rs;
        logic [WIDTH+1:0]  exp;
        int                seen;
        bit                stall;

        reset     = 1'b1;
        in_valid  = '0;
        out_ready = '1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        repeat (3) tick();
        check("in_ready during reset", 32'(in_ready[1]), 32'd0);
        reset = 1'b0;
        #1;
        for (int k = 0; k < NCFG; k++) begin
            check("reset out_valid", 32'(out_valid[k]), 32'd0);
            check("reset out", 32'(out[k]), 32'd0);
            check("reset overflow", 32'(overflow[k]), 32'd0);
            check("reset in_ready", 32'(in_ready[k]), 32'd1);
        end

        // Directed cases on CHUNK=2 (N=4)
        start_op(1, 8'h5A, 8'h33, 1'b0, 1'b0);
        wait_result(1, 4, 9'h08D, 1'b1, "add");
        start_op(1, 8'hFF, 8'h01, 1'b1, 1'b0);
        wait_result(1, 4, 9'h101, 1'b0, "wrap");
        start_op(1, 8'h10, 8'h20, 1'b1, 1'b1);
        wait_result(1, 4, 9'h0F0, 1'b0, "sub borrow");
        start_op(1, 8'h80, 8'h01, 1'b0, 1'b1);
        wait_result(1, 4, 9'h17F, 1'b1, "sub overflow");

        // Backpressure with pending operands, then simultaneous handshakes
        start_op(1, 8'h3C, 8'h4B, 1'b0, 1'b0);
        out_ready[1] = 1'b0;
        wait_result(1, 4, 9'h087, 1'b1, "bp");
        a = 8'h01; b = 8'h02; cin = 1'b0; sub = 1'b0;
        in_valid[1] = 1'b1;
        repeat (5) begin
            tick();
            check("bp out held", 32'(out[1]), 32'h087);
            check("bp out_valid held", 32'(out_valid[1]), 32'd1);
            check("bp in_ready low", 32'(in_ready[1]), 32'd0);
        end
        out_ready[1] = 1'b1;
        #1;
        check("b2b in_ready", 32'(in_ready[1]), 32'd1);
        tick();
        in_valid[1] = 1'b0;
        check("b2b out_valid drop", 32'(out_valid[1]), 32'd0);
        wait_result(1, 4, 9'h003, 1'b0, "b2b");

        // Reset at BUSY index 2 aborts the operation
        start_op(1, 8'h11, 8'h22, 1'b0, 1'b0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("abort in_ready in reset", 32'(in_ready[1]), 32'd0);
        check("abort out cleared", 32'(out[1]), 32'd0);
        check("abort out_valid", 32'(out_valid[1]), 32'd0);
        reset = 1'b0;
        #1;
        check("abort in_ready after", 32'(in_ready[1]), 32'd1);
        seen = 0;
        repeat (8) begin
            tick();
            if (out_valid[1]) seen++;
        end
        check("abort no out_valid", 32'(seen), 32'd0);
        start_op(1, 8'h03, 8'h04, 1'b0, 1'b0);
        wait_result(1, 4, 9'h007, 1'b0, "after abort");

        // Random sweep on every chunk size
        for (int k = 0; k < NCFG; k++) begin
            repeat (1000) begin
                ra    = WIDTH'($urandom);
                rb    = WIDTH'($urandom);
                rc    = 1'($urandom);
                rs    = 1'($urandom);
                exp   = model(ra, rb, rc, rs);
                stall = ($urandom_range(0, 3) == 0);
                start_op(k, ra, rb, rc, rs);
                if (stall) out_ready[k] = 1'b0;
                wait_result(k, WIDTH >> k, exp[WIDTH:0], exp[WIDTH+1], $sformatf("rand c%0d", 1 << k));
                if (stall) begin
                    repeat ($urandom_range(1, 3)) begin
                        tick();
                        check("rand stall out", 32'(out[k]), 32'(exp[WIDTH:0]));
                        check("rand stall in_ready", 32'(in_ready[k]), 32'd0);
                    end
                    out_ready[k] = 1'b1;
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/chunked_adder.md
Name: chunked_adder

Overview:
- Multi-cycle, parametrised add/subtract unit. Successor to the 2-bit combinational adder.
- Processes WIDTH-bit operands CHUNK bits per clock, least-significant chunk first, through a registered carry chain.
- Adds carry-in, subtract mode, signed-overflow flag and valid/ready handshakes on both sides.
- Sits between operand producers and result consumers where a full-width single-cycle carry chain is too slow or too large.

Parameters:
- WIDTH, 8, operand width in bits; must be a multiple of CHUNK.
- CHUNK, 2, bits summed per cycle; 1 <= CHUNK <= WIDTH.

Ports:
- clock  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous reset, active-high.
- in_valid  input  1  operand request valid.
- in_ready  output  1  unit can accept operands.
- a  input  WIDTH  operand A, unsigned or two's complement.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in; ignored when sub=1.
- sub  input  1  0: a+b+cin; 1: a-b, computed as a+~b+1.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out  output  WIDTH+1  {carry_out, sum}; for sub, out[WIDTH]=1 means no borrow.
- overflow  output  1  signed overflow of the WIDTH-bit result.

Behaviour:
- Derived constants: N = WIDTH/CHUNK; chunk index register width = max(1, clog2(N)).
- States:
  - IDLE: in_ready=1, out_valid=0.
  - BUSY: in_ready=0, out_valid=0.
  - DONE: out_valid=1, in_ready=out_ready.
- Reset (synchronous):
  - state=IDLE; out=0; overflow=0; out_valid=0; carry, index and operand registers cleared.
  - in_ready=0 while reset is high.
  - Reset asserted in BUSY or DONE aborts the operation; the result is discarded and no out_valid pulse is produced.
- Accept: in_valid&&in_ready at a rising edge.
  - Captures a; captures b (inverted if sub).
  - Sets carry = sub ? 1 : cin; index=0; state goes to BUSY.
  - a, b, cin and sub are don't-care after acceptance.
- BUSY, each edge:
  - {c, s} = A[idx*CHUNK +: CHUNK] + B[idx*CHUNK +: CHUNK] + carry.
  - s is written into result bits idx*CHUNK +: CHUNK; carry <= c; idx++.
  - On the edge where idx==N-1: out[WIDTH] <= c; overflow <= carry into MSB XOR carry out of MSB; state goes to DONE.
- Latency: out_valid rises exactly N edges after the accepting edge (N=1: one BUSY cycle).
- DONE:
  - out and overflow are held stable until out_valid&&out_ready.
  - On that handshake alone: state goes to IDLE.
  - On that handshake with a simultaneous in_valid: new operands are accepted on the same edge, state goes to BUSY and out_valid drops.
- Throughput: one operation per N+1 cycles with an always-ready consumer.
- Backpressure: out_ready low holds DONE indefinitely; no operands are accepted.
- Register content:
  - Result bits not yet computed in BUSY hold stale values, but out is only defined while out_valid=1.
  - out is registered, never combinational from a or b.
- Wrap-around: the sum is modulo 2^WIDTH; carry-out is reported in out[WIDTH] and never dropped.

Decomposition:
- Package chunked_adder_pkg:
  - state enum {IDLE, BUSY, DONE};
  - function computing the index width from WIDTH/CHUNK;
  - elaboration-time check that WIDTH % CHUNK == 0.
- Sub-module chunk_add_slice: combinational CHUNK-bit ripple adder.
  - Inputs: a_c, b_c, c_in. Outputs: s, c_out, c_msb_in (carry into the top bit, used for overflow).
  - One instance per chunked_adder.

Test Plan (WIDTH=8, CHUNK=2, so N=4):
- Add: a=0x5A, b=0x33, cin=0, sub=0, out_ready=1 -> out_valid 4 edges after accept; out=0x08D; overflow=1 (90+51=141 > 127).
- Carry/wrap: a=0xFF, b=0x01, cin=1 -> out=0x101; overflow=0.
- Subtract: a=0x10, b=0x20, sub=1, cin=1 (ignored) -> out=0x0F0 (no-borrow bit 0); overflow=0. Then a=0x80, b=0x01, sub=1 -> out=0x17F; overflow=1.
- Backpressure and back-to-back:
  - Hold out_ready=0 for 5 cycles -> out stable, in_ready=0.
  - Then raise out_ready with in_valid high (a=0x01, b=0x02) -> both handshakes on the same edge; next result 0x003 exactly 4 edges later.
- Reset mid-op: assert reset for 1 cycle at BUSY index 2 -> out_valid never rises for that operation; out=0; in_ready=1 on the cycle after reset deasserts; a following op a=0x03, b=0x04 yields 0x007.
- Parameter sweep: CHUNK=1, 4, 8 with 1000 random ops each against a reference model -> results match; latency = WIDTH/CHUNK.
